// File: rtl/serial_sub.sv
// serial_sub -- bit-serial subtractor computing diff = a - b - bin (mod 2^WIDTH).
//
// One bit is processed per clock, LSB first, through a 1-bit full subtractor.
// A subtraction takes WIDTH clocks in SHIFT after the accepting edge, then
// one cycle in DONE with done high. Operations can run back-to-back with no
// idle gap if start is held high through DONE.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32), default 8
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  begin a subtraction (accepted in IDLE or DONE only)
//   a, b   minuend / subtrahend, sampled on the accepting edge
//   bin    borrow-in, sampled on the accepting edge
//   busy   high while in SHIFT
//   done   one-cycle pulse while in DONE
//   diff   result, updated only when an operation completes
//   bout   borrow-out (1 when unsigned a < b + bin)
//   ovf    signed overflow flag; present only when SERIAL_SUB_OVF_EN is defined
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf output and its logic.

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor slice for the bit selected by the counter.
  logic             bit_a, bit_b, d_bit, bw_nx;
  logic [WIDTH-1:0] res_upd;

  always_comb begin
    bit_a   = a_q[cnt_q];
    bit_b   = b_q[cnt_q];
    d_bit   = bit_a ^ bit_b ^ bw_q;
    bw_nx   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bw_q);
    // Result word with the current bit merged in; on the last bit this is
    // the complete difference and goes straight to diff.
    res_upd = res_q;
    res_upd[cnt_q] = d_bit;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          bw_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // start is deliberately not looked at here.
        res_d = res_upd;
        bw_d  = bw_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          diff_d  = res_upd;
          bout_d  = bw_nx;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_upd[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bw_q    <= bw_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub (WIDTH=8): table of vectors plus hand-written
// sequences for mid-operation start, reset abort and back-to-back operation.
// Results are checked by a scoreboard queue filled when a start is driven and
// drained whenever done is seen.

module tb_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W-1:0] last_diff;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: 9-bit arithmetic.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    e.diff = full[W-1:0];
    e.bout = ({1'b0, ma} < ({1'b0, mb} + {{W{1'b0}}, mbin}));
    e.ovf  = (ma[W-1] != mb[W-1]) && (e.diff[W-1] != ma[W-1]);
    return e;
  endfunction

  // Scoreboard consumer: one line per completed transaction.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("[TB] done: diff=0x%02h bout=%0d (expect 0x%02h/%0d)", diff, bout, e.diff, e.bout);
        chk("diff", 32'(diff), 32'(e.diff));
        chk("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        last_diff = e.diff;
      end
    end
  end

  // Called at a negedge: drives operands + start, lets the accepting edge
  // pass, and returns at the following negedge with start dropped.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin, input exp_t e);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, counting edges since the accepting edge (e0 already passed).
  task automatic wait_done(input int e0, output int edges);
    logic busy_bad;
    busy_bad = 1'b0;
    edges = e0;
    while (!done && edges < 24) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("done_latency", 32'(edges), 32'd8);
    chk("busy_during_shift", 32'(busy_bad), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd0);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin, input exp_t e);
    int edges;
    launch(ta, tb_v, tbin, e);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_done(0, edges);
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int edges;
    int done_cnt;
    int d_edge[$];
    exp_t e;

    vecs[0] = '{8'h0F, 8'h05, 1'b0, 8'h0A, 1'b0, 1'b0};
    vecs[1] = '{8'h05, 8'h0F, 1'b0, 8'hF6, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};
    vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_diff = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    // Release reset and start on the very first edge with rst low.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e.diff = vecs[i].diff; e.bout = vecs[i].bout; e.ovf = vecs[i].ovf;
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, e);
      chk("diff_held_after_done", 32'(diff), 32'(vecs[i].diff));
    end

    // start re-pulsed at E3 with different operands must be ignored, and
    // diff must keep the previous result while shifting.
    launch(8'h0F, 8'h05, 1'b0, model(8'h0F, 8'h05, 1'b0));
    @(posedge clk); @(negedge clk);         // after E1
    @(posedge clk); @(negedge clk);         // after E2
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk);                         // E3
    @(negedge clk);
    start = 1'b0;
    chk("diff_hold_in_shift", 32'(diff), 32'(vecs[9].diff));
    chk("busy_after_ignored_start", 32'(busy), 32'd1);
    wait_done(3, edges);
    @(negedge clk);

    // Reset at E4 abandons the operation with no done pulse.
    launch(8'h33, 8'h11, 1'b0, model(8'h33, 8'h11, 1'b0));
    repeat (3) begin @(posedge clk); @(negedge clk); end   // after E3
    rst = 1'b1;
    @(posedge clk);                         // E4
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    sb.delete();
    done_cnt = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    do_op(8'h0F, 8'h05, 1'b0, model(8'h0F, 8'h05, 1'b0));

    // start held high through DONE: three operations, done every 9 cycles.
    a = 8'h0F; b = 8'h05; bin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h0F, 8'h05, 1'b0));
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk);                       // edge Ek
      @(negedge clk);
      if (done) d_edge.push_back(k);
      if (k == 1) begin
        a = 8'h05; b = 8'h0F; bin = 1'b1;
        sb.push_back(model(8'h05, 8'h0F, 1'b1));
      end
      if (k == 9) begin
        chk("b2b_no_idle_gap", 32'(busy), 32'd1);
        a = 8'hC3; b = 8'h3C; bin = 1'b0;
        sb.push_back(model(8'hC3, 8'h3C, 1'b0));
      end
      if (k == 18) start = 1'b0;
    end
    chk("b2b_done_count", 32'(d_edge.size()), 32'd3);
    if (d_edge.size() == 3) begin
      chk("b2b_done1", 32'(d_edge[0]), 32'd8);
      chk("b2b_done2", 32'(d_edge[1]), 32'd17);
      chk("b2b_done3", 32'(d_edge[2]), 32'd26);
    end
    chk("b2b_idle_after", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction.
REQ-005 SHALL have port a  input  WIDTH  minuend, sampled on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, sampled on the accepting edge.
REQ-007 SHALL have port bin  input  1  borrow-in, sampled on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a completed result.
REQ-010 SHALL have port diff  output  WIDTH  result a - b - bin modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow-out; 1 when unsigned a < b + bin.

Function
REQ-012 SHALL implement three states: IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE or DONE: on that edge, latch a, b and bin, clear the bit counter, and enter SHIFT.
REQ-014 SHALL ignore start while in SHIFT, with no effect on the operation in progress.
REQ-015 SHALL process one bit per clock in SHIFT, LSB first, using a 1-bit full subtractor: d = a^b^bw; bw_next = (~a&b) | (~(a^b)&bw); bw is initialised to the latched bin.
REQ-016 SHALL leave SHIFT for DONE on the edge that processes bit WIDTH-1, i.e. WIDTH edges after the accepting edge.
REQ-017 SHALL, on the SHIFT-to-DONE edge, load diff with the assembled result and bout with the final borrow.
REQ-018 SHALL hold diff and bout at their previous values throughout SHIFT; partial results SHALL NOT be visible.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE.
REQ-020 SHALL move from DONE to IDLE when start is low, and from DONE to SHIFT when start is high; back-to-back operations therefore have no idle gap.
REQ-021 SHALL assert busy if and only if the state is SHIFT.
REQ-022 SHALL keep diff and bout stable from the DONE cycle until the next SHIFT-to-DONE edge or reset.
REQ-023 SHALL take all arithmetic modulo 2^WIDTH, with no sign interpretation except under REQ-027.

Reset
REQ-024 SHALL, on the first clk edge with rst high, enter IDLE and drive busy=0, done=0, diff=0 and bout=0, clearing the counter, internal borrow and operand registers.
REQ-025 SHALL give rst priority over start on the same edge; an operation in SHIFT SHALL be abandoned and produce no done.
REQ-026 SHALL accept a start on the first edge after rst deasserts.

Configuration
REQ-027 SHALL, when macro SERIAL_SUB_OVF_EN is defined, add output port ovf (1 bit), loaded on the SHIFT-to-DONE edge with the signed overflow (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), reset to 0, and held under the same rules as diff.
REQ-028 SHALL, when SERIAL_SUB_OVF_EN is undefined, omit the ovf port and its logic, leaving all other behaviour identical.

Verification (WIDTH=8)
REQ-029 SHALL cover: a=0x0F, b=0x05, bin=0, start accepted at edge E0 -> done high only in the cycle after E8, diff=0x0A, bout=0, busy high from E0 to E8.
REQ-030 SHALL cover: a=0x05, b=0x0F, bin=0 -> diff=0xF6, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-031 SHALL cover: with SERIAL_SUB_OVF_EN, a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x10, b=0x01 -> diff=0x0F, ovf=0.
REQ-032 SHALL cover: start pulsed again at E3 with a=0xFF, b=0x00 -> ignored; result stays 0x0F-0x05=0x0A at E8.
REQ-033 SHALL cover: rst high at E4 mid-operation -> busy=0, done=0, diff=0, bout=0 on the next cycle and no done pulse; a new start then completes correctly.
REQ-034 SHALL cover: start held high through DONE -> the second operation begins with no idle cycle, and done pulses every 9 cycles.
